pi_req_queue: RTL

- Posted-request queue between the synchronized Pi register-write port and the 68k bus access state machine.
- Captures DATA_LO/DATA_HI/ADDR_LO writes into staging registers.
- On each ADDR_HI write, pushes a complete request {fc, read, size, address, data} into a small FIFO. The bus engine pops requests in order.
- Collects read results and produces the combined req_active flag (GPIO3), so the Pi can post several writes without waiting for each bus cycle.

---
 rtl/pi_req_queue.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pi_req_queue.sv
// Posted-request queue between the Pi register-write port and the 68k bus engine.
// Staging registers are assembled into {fc, read, size, address, data} entries and held in a first-word-fall-through FIFO.
module pi_req_queue #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  sys_clk,
  input  logic                  nRESET,
  input  logic                  wr_strobe,
  input  logic [2:0]            wr_addr,
  input  logic [15:0]           wr_data,
  output logic                  q_valid,
  input  logic                  q_ready,
  output logic [23:0]           q_address,
  output logic [2:0]            q_fc,
  output logic                  q_read,
  output logic [1:0]            q_size,
  output logic [31:0]           q_data,
  input  logic                  bus_busy,
  input  logic                  rd_done,
  input  logic [31:0]           rd_data,
  output logic [31:0]           rdata,
  output logic                  req_active,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {
    REG_DATA_LO = 3'd0,
    REG_DATA_HI = 3'd1,
    REG_ADDR_LO = 3'd2,
    REG_ADDR_HI = 3'd3,
    REG_CTRL    = 3'd4,
    REG_CLR_OVF = 3'd5,
    REG_STATUS  = 3'd6,
    REG_VERSION = 3'd7
  } reg_addr_e;

  typedef struct packed {
    logic [2:0]  fc;
    logic        read;
    logic [1:0]  size;
    logic [23:0] address;
    logic [31:0] data;
  } entry_t;

  entry_t                mem_q [DEPTH];
  logic [31:0]           stage_data_q, stage_data_d;
  logic [15:0]           stage_addr_q, stage_addr_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  overflow_q, overflow_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;

  logic   push_req, push_ok, pop;
  entry_t push_entry, head;

  assign head      = mem_q[rd_ptr_q];
  assign q_valid   = (level_q != '0);
  assign q_address = head.address;
  assign q_fc      = head.fc;
  assign q_read    = head.read;
  assign q_size    = head.size;
  assign q_data    = head.data;
  assign rdata     = rdata_q;
  assign overflow  = overflow_q;
  assign level     = level_q;
  assign req_active = (level_q != '0) | bus_busy;

  assign pop      = q_valid & q_ready;
  assign push_req = wr_strobe & (wr_addr == REG_ADDR_HI);
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req & ((level_q < FULL) | pop);

  always_comb begin
    push_entry         = '0;
    push_entry.address = {wr_data[7:0], stage_addr_q};
    push_entry.size    = wr_data[9:8];
    push_entry.read    = wr_data[10];
    push_entry.fc      = wr_data[13:11];
    push_entry.data    = stage_data_q;
  end

  always_comb begin
    stage_data_d = stage_data_q;
    stage_addr_d = stage_addr_q;
    overflow_d   = overflow_q;
    rdata_d      = rd_done ? rd_data : rdata_q;
    wr_ptr_d     = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d      = level_q;

    if (wr_strobe) begin
      unique case (wr_addr)
        REG_DATA_LO: stage_data_d[15:0]  = wr_data;
        REG_DATA_HI: stage_data_d[31:16] = wr_data;
        REG_ADDR_LO: stage_addr_d        = wr_data;
        REG_ADDR_HI: if (!push_ok) overflow_d = 1'b1;
        REG_CLR_OVF: overflow_d          = 1'b0;
        default: ;
      endcase
    end

    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge nRESET) begin
    if (!nRESET) begin
      stage_data_q <= '0;
      stage_addr_q <= '0;
      rdata_q      <= '0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
    end else begin
      stage_data_q <= stage_data_d;
      stage_addr_q <= stage_addr_d;
      rdata_q      <= rdata_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
    end
  end

  // Storage needs no reset: entries are only observed while level is non-zero.
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule
